tone_sequencer_poly: RTL and testbench

Parametrised successor to the single-voice tone generator: a multi-voice square-wave sequencer core with run/pause control, runtime-programmable note duration and a first-order sigma-delta mixer driving one 1-bit audio pin. It owns the tempo strobe, the step counter, per-voice phase counters and the mixer. Divider values come from an external notes ROM indexed by `step_o`, one divider per voice. The TinyTapeout top instantiates it and routes `sound_o` to `uo_out[0]`.

---
 rtl/tone_sequencer_poly.sv | 120 ++++++++++++
 tb/tb_tone_sequencer_poly.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer_poly.sv
// Multi-voice square-wave sequencer: tempo strobe, step counter, per-voice phase
// counters and a first-order sigma-delta mixer. Optional articulation gap: TONE_SEQ_GAP_EN.
module tone_sequencer_poly #(
  parameter int VOICES  = 2,
  parameter int DIV_BW  = 16,
  parameter int DUR_BW  = 24,
  parameter int SEQ_LEN = 64,
  parameter int SEQ_BW  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     play_i,
  input  logic                     restart_i,
  input  logic [DUR_BW-1:0]        note_dur_i,
  input  logic [VOICES*DIV_BW-1:0] divider_i,
  output logic [SEQ_BW-1:0]        step_o,
  output logic                     strb_o,
  output logic [VOICES-1:0]        voice_o,
  output logic                     sound_o
);

  localparam int ACC_BW = $clog2(VOICES) + 1;
  localparam int SUM_BW = ACC_BW + 1;

  logic [DUR_BW-1:0] tempo_cnt;
  logic [DUR_BW-1:0] dur_eff;
  logic [DUR_BW-1:0] last_cnt;
  logic              wrap;
  logic              clear_phase;
  logic              gap;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    dur_eff     = (note_dur_i < DUR_BW'(2)) ? DUR_BW'(2) : note_dur_i;
    last_cnt    = dur_eff - DUR_BW'(1);
    // ">=" rather than "==" so a shortened duration wraps immediately.
    wrap        = play_i && !restart_i && (tempo_cnt >= last_cnt);
    clear_phase = strb_o || restart_i;
  end

`ifdef TONE_SEQ_GAP_EN
  logic [DUR_BW-1:0] gap_len;
  assign gap_len = dur_eff >> 3;
  assign gap     = (gap_len != '0) && (tempo_cnt >= dur_eff - gap_len);
`else
  assign gap = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tempo_cnt <= '0;
      strb_o    <= 1'b0;
      step_o    <= '0;
    end else begin
      strb_o <= wrap;
      if (!play_i || restart_i || wrap) tempo_cnt <= '0;
      else                              tempo_cnt <= tempo_cnt + DUR_BW'(1);

      if (restart_i)   step_o <= '0;
      else if (strb_o) step_o <= (step_o == SEQ_BW'(SEQ_LEN - 1)) ? '0 : step_o + SEQ_BW'(1);
    end
  end

  logic [DIV_BW-1:0] div   [VOICES];
  logic [DIV_BW-1:0] phase [VOICES];

  for (genvar gv = 0; gv < VOICES; gv++) begin : g_div
    assign div[gv] = divider_i[gv*DIV_BW +: DIV_BW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the phase array is a handful of flops, not a RAM, so it is reset like any other state.
      for (int v = 0; v < VOICES; v++) phase[v] <= '0;
      voice_o <= '0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        if (!play_i || div[v] < DIV_BW'(2)) begin
          phase[v]   <= '0;
          voice_o[v] <= 1'b0;
        end else if (gap) begin
          voice_o[v] <= 1'b0;
        end else begin
          voice_o[v] <= phase[v] < (div[v] >> 1);
          // Wrap also covers a divider that shrank below the current phase.
          if (clear_phase || phase[v] >= div[v] - DIV_BW'(1)) phase[v] <= '0;
          else                                                phase[v] <= phase[v] + DIV_BW'(1);
        end
      end
    end
  end

  logic [ACC_BW-1:0] acc;
  logic [SUM_BW-1:0] voice_sum;
  logic [SUM_BW-1:0] mix_sum;

  always_comb begin
    voice_sum = '0;
    for (int v = 0; v < VOICES; v++) voice_sum = voice_sum + SUM_BW'(voice_o[v]);
    mix_sum = SUM_BW'(acc) + voice_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      sound_o <= 1'b0;
    end else if (!play_i) begin
      acc     <= '0;
      sound_o <= 1'b0;
    end else if (mix_sum >= SUM_BW'(VOICES)) begin
      acc     <= ACC_BW'(mix_sum - SUM_BW'(VOICES));
      sound_o <= 1'b1;
    end else begin
      acc     <= ACC_BW'(mix_sum);
      sound_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_sequencer_poly.sv
// Self-checking bench for tone_sequencer_poly: directed scenarios plus randomized play,
// restart, duration and ROM changes, compared every cycle against a behavioural model.
module tb_tone_sequencer_poly;

  localparam int VOICES  = 2;
  localparam int DIV_BW  = 16;
  localparam int DUR_BW  = 24;
  localparam int SEQ_LEN = 4;
  localparam int SEQ_BW  = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     play_i;
  logic                     restart_i;
  logic [DUR_BW-1:0]        note_dur_i;
  logic [VOICES*DIV_BW-1:0] divider_i;
  logic [SEQ_BW-1:0]        step_o;
  logic                     strb_o;
  logic [VOICES-1:0]        voice_o;
  logic                     sound_o;

  int rom [SEQ_LEN][VOICES];

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  int          m_cnt;
  int          m_step;
  logic        m_strb;
  int          m_phase [VOICES];
  logic [VOICES-1:0] m_voice;
  int          m_acc;
  logic        m_sound;

  tone_sequencer_poly #(
    .VOICES (VOICES), .DIV_BW(DIV_BW), .DUR_BW(DUR_BW), .SEQ_LEN(SEQ_LEN), .SEQ_BW(SEQ_BW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .play_i     (play_i),
    .restart_i  (restart_i),
    .note_dur_i (note_dur_i),
    .divider_i  (divider_i),
    .step_o     (step_o),
    .strb_o     (strb_o),
    .voice_o    (voice_o),
    .sound_o    (sound_o)
  );

  always #5 clk = ~clk;

  // Combinational notes ROM addressed by the DUT's step
  always_comb begin
    divider_i = '0;
    for (int v = 0; v < VOICES; v++)
      if (int'(step_o) < SEQ_LEN) divider_i[v*DIV_BW +: DIV_BW] = DIV_BW'(rom[step_o][v]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_step = 0; m_strb = 1'b0; m_voice = '0; m_acc = 0; m_sound = 1'b0;
    for (int v = 0; v < VOICES; v++) m_phase[v] = 0;
  endtask

  // One rising edge of the reference: everything on the right is the pre-edge state.
  task automatic model_clock();
    int   d, s, t, dv, old_step;
    logic wrap, clr, gap, old_strb;
    if (!rst_n) begin
      model_reset();
      return;
    end
    d        = (note_dur_i < 2) ? 2 : int'(note_dur_i);
    old_step = m_step;
    old_strb = m_strb;
    wrap     = play_i && !restart_i && (m_cnt >= d - 1);
    clr      = old_strb || restart_i;
    gap      = 1'b0;
`ifdef TONE_SEQ_GAP_EN
    gap = (d / 8 > 0) && (m_cnt >= d - d / 8);
`endif
    s = 0;
    for (int v = 0; v < VOICES; v++) s += int'(m_voice[v]);
    t = m_acc + s;
    if (!play_i)          begin m_acc = 0;          m_sound = 1'b0; end
    else if (t >= VOICES) begin m_acc = t - VOICES; m_sound = 1'b1; end
    else                  begin m_acc = t;          m_sound = 1'b0; end

    for (int v = 0; v < VOICES; v++) begin
      dv = rom[old_step][v];
      if (!play_i || dv < 2) begin
        m_phase[v] = 0;
        m_voice[v] = 1'b0;
      end else if (gap) begin
        m_voice[v] = 1'b0;
      end else begin
        m_voice[v] = (m_phase[v] < dv / 2);
        m_phase[v] = (clr || m_phase[v] + 1 >= dv) ? 0 : m_phase[v] + 1;
      end
    end

    m_cnt  = (wrap || !play_i || restart_i) ? 0 : m_cnt + 1;
    m_step = restart_i ? 0 : (old_strb ? (old_step + 1) % SEQ_LEN : old_step);
    m_strb = wrap;
  endtask

  task automatic compare_all();
    check("step_o",  32'(step_o),  32'(m_step));
    check("strb_o",  32'(strb_o),  32'(m_strb));
    check("voice_o", 32'(voice_o), 32'(m_voice));
    check("sound_o", 32'(sound_o), 32'(m_sound));
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_clock();
      #1;
      compare_all();
    end
  endtask

  task automatic fill_rom(input int d0, input int d1);
    for (int s = 0; s < SEQ_LEN; s++) begin
      rom[s][0] = d0;
      rom[s][1] = d1;
    end
  endtask

  task automatic pulse_restart();
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
  endtask

  initial begin
    int cnt, guard;
    rst_n = 1'b0; play_i = 1'b0; restart_i = 1'b0; note_dur_i = 24'd10;
    fill_rom(0, 0);
    model_reset();

    // Reset state
    tick(2);
    rst_n = 1'b1;

    // Tempo: D=10, four-step sequence, random dividers
    for (int s = 0; s < SEQ_LEN; s++)
      for (int v = 0; v < VOICES; v++) rom[s][v] = $urandom_range(0, 15);
    play_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt += int'(strb_o);
    end
    check("strobes_in_40", cnt, 4);
    tick(10);

    // Divider 8 and rest
    note_dur_i = 24'd1000;
    fill_rom(8, 0);
    pulse_restart();
    tick(10);
    cnt = 0;
    guard = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cnt += int'(voice_o[0]);
      guard += int'(voice_o[1]);
    end
    check("div8_high", cnt, 8);
    check("rest_high", guard, 0);

    // Both voices divider 8
    fill_rom(8, 8);
    pulse_restart();
    tick(10);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cnt += int'(sound_o);
    end
    check("dual8_sound_high", cnt, 8);

    // Divider 12 and divider 1
    fill_rom(12, 1);
    pulse_restart();
    tick(10);
    cnt = 0;
    guard = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      cnt += int'(voice_o[0]);
      guard += int'(voice_o[1]);
    end
    check("div12_high", cnt, 12);
    check("div1_high", guard, 0);

    // Pause at step 2, then resume with full duration
    note_dur_i = 24'd10;
    for (int s = 0; s < SEQ_LEN; s++)
      for (int v = 0; v < VOICES; v++) rom[s][v] = $urandom_range(2, 9);
    pulse_restart();
    guard = 0;
    while (step_o !== 3'd2 && guard < 100) begin
      tick();
      guard++;
    end
    check("reach_step2", 32'(step_o), 32'd2);
    tick(3);
    play_i = 1'b0;
    tick(2);
    check("pause_sound", 32'(sound_o), 32'd0);
    tick(48);
    check("pause_step_hold", 32'(step_o), 32'd2);
    play_i = 1'b1;
    cnt = 0;
    while (strb_o !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("resume_latency", cnt, 10);

    // Restart on the tempo-wrap cycle
    guard = 0;
    while (m_cnt != 9 && guard < 40) begin
      tick();
      guard++;
    end
    check("wrap_wait_ok", 32'(guard < 40), 32'd1);
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    check("restart_no_strb", 32'(strb_o), 32'd0);
    check("restart_step0", 32'(step_o), 32'd0);
    tick(12);

    // Randomized run: play, restart, duration and ROM changes
    for (int s = 0; s < SEQ_LEN; s++)
      for (int v = 0; v < VOICES; v++) rom[s][v] = $urandom_range(0, 20);
    for (int i = 0; i < 1500; i++) begin
      play_i    = ($urandom_range(0, 19) != 0);
      restart_i = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) note_dur_i = DUR_BW'($urandom_range(0, 24));
      if ($urandom_range(0, 79) == 0)
        rom[$urandom_range(0, SEQ_LEN - 1)][$urandom_range(0, VOICES - 1)] = $urandom_range(0, 20);
      tick();
    end
    restart_i = 1'b0;
    play_i    = 1'b1;
    note_dur_i = 24'd10;
    fill_rom(6, 4);
    tick(25);

    // Asynchronous reset mid-note
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_step",  32'(step_o),  32'd0);
    check("arst_strb",  32'(strb_o),  32'd0);
    check("arst_voice", 32'(voice_o), 32'd0);
    check("arst_sound", 32'(sound_o), 32'd0);
    model_reset();
    tick(2);
    rst_n = 1'b1;
    tick();
    check("post_reset_step", 32'(step_o), 32'd0);
    tick(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
